// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and default sizing for the uart_tx byte-stream arbiter.
// Defaults match the downstream uart_tx FIFO.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int WIDTH_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int MAX_BURST_DEF  = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority search: first set request at or after ptr.
// Pure combinational; the lowest offset from ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    // Walk offsets high to low so the nearest hit is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte streams into a single uart_tx with burst-limited grants
// and credit flow control against the uart_tx FIFO depth.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_wr_en,
  output logic [WIDTH-1:0]            uart_data,
  output logic                        uart_start,
  input  logic                        uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        owner_valid,
  output logic [$clog2(FIFO_DEPTH):0] credits_used
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_d;
  logic [IW-1:0] rr_ptr, rr_d;
  logic [BW-1:0] burst_cnt, burst_d;
  logic [CW-1:0] credits_d;
  logic          busy_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          has_room;
  logic          grant_ok;
  logic          xfer;
  logic          grant_end;
  logic          byte_done;

  logic [WIDTH-1:0] bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign bytes[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign has_room  = credits_used < CW'(FIFO_DEPTH);
  assign grant_ok  = (state_q == LOCK) && has_room && !rst;
  assign xfer      = grant_ok && req_valid[owner];
  assign grant_end = req_last[owner] ||
                     (burst_cnt == BW'(MAX_BURST - 1));
  // A busy fall with nothing outstanding is stale and ignored.
  assign byte_done = busy_q && !uart_busy &&
                     (credits_used != '0);

  assign uart_wr_en  = xfer;
  assign uart_data   = xfer ? bytes[owner] : '0;
  assign uart_start  = !rst && (credits_used != '0);
  assign owner_valid = (state_q == LOCK);

  always_comb begin
    req_ready = '0;
    if (grant_ok) req_ready[owner] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner;
    rr_d      = rr_ptr;
    burst_d   = burst_cnt;
    credits_d = credits_used;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCK;
          owner_d = pick_idx;
          burst_d = '0;
        end
      end
      LOCK: begin
        if (xfer) begin
          burst_d = burst_cnt + 1'b1;
          if (grant_end) begin
            state_d = IDLE;
            rr_d    = (owner == IW'(NUM_REQ - 1)) ?
                      '0 : owner + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    unique case ({xfer, byte_done})
      2'b10:   credits_d = credits_used + 1'b1;
      2'b01:   credits_d = credits_used - 1'b1;
      default: credits_d = credits_used;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      credits_used <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner        <= owner_d;
      rr_ptr       <= rr_d;
      burst_cnt    <= burst_d;
      credits_used <= credits_d;
      busy_q       <= uart_busy;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter.
// Requester queues feed bytes; expected {owner,data} are queued up front.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int FD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         uart_wr_en;
  logic [W-1:0] uart_data;
  logic         uart_start;
  logic         uart_busy;
  logic [1:0]   owner;
  logic         owner_valid;
  logic [4:0]   credits_used;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] en = '0;
  logic [N-1:0] fire = '0;
  logic         busy_man = 1'b0;
  logic         auto_busy = 1'b0;
  int           phase = 0;
  logic [8:0]   mem [N][64];
  int           hd [N];
  int           tl [N];
  logic [9:0]   sb [$];
  int           wr_times [$];
  int           cyc = 0;
  int           grants = 0;
  int           cmodel = 0;
  logic         bprev = 1'b0;
  logic         ov_prev = 1'b0;
  logic [9:0]   exp_e;
  logic         fall;

  uart_tx_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_wr_en   (uart_wr_en),
    .uart_data    (uart_data),
    .uart_start   (uart_start),
    .uart_busy    (uart_busy),
    .owner        (owner),
    .owner_valid  (owner_valid),
    .credits_used (credits_used)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int r, input logic [7:0] d, input logic l);
    mem[r][tl[r]] = {l, d};
    tl[r]++;
  endtask

  task automatic expect_b(input logic [1:0] r, input logic [7:0] d);
    sb.push_back({r, d});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    en = '0;
    busy_man = 1'b0;
    auto_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Requester and uart_tx busy drivers.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++)
      if (fire[i] && hd[i] < tl[i]) hd[i]++;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = en[i] && (hd[i] < tl[i]);
      req_data[i*W +: W] = mem[i][hd[i]][7:0];
      req_last[i]        = mem[i][hd[i]][8];
    end
    phase = (phase == 2) ? 0 : phase + 1;
    uart_busy = auto_busy ? (phase != 2) : busy_man;
  end

  // Output monitor, scoreboard pop and credit reference.
  always @(negedge clk) begin
    cyc++;
    fire = req_valid & req_ready;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_wr_en", 32'(uart_wr_en), 32'd0);
      chk("rst_start", 32'(uart_start), 32'd0);
      chk("rst_data", 32'(uart_data), 32'd0);
      cmodel = 0;
      bprev = 1'b0;
      ov_prev = 1'b0;
    end else begin
      chk("credits", 32'(credits_used), 32'(cmodel));
      chk("start", 32'(uart_start), 32'(cmodel != 0));
      if (owner_valid && !ov_prev) grants++;
      ov_prev = owner_valid;
      if (uart_wr_en) begin
        wr_times.push_back(cyc);
        chk("wr_room", 32'(cmodel < FD), 32'd1);
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(uart_data), 32'hdead);
        end else begin
          exp_e = sb.pop_front();
          chk("wr_owner", 32'(owner), 32'(exp_e[9:8]));
          chk("wr_data", 32'(uart_data), 32'(exp_e[7:0]));
        end
      end
      fall = bprev && !uart_busy;
      if (uart_wr_en && !(fall && cmodel != 0)) cmodel++;
      else if (!uart_wr_en && fall && cmodel != 0) cmodel--;
      bprev = uart_busy;
    end
  end

  initial begin
    int w0;
    int g0;
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w0;
    int g0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_owner_valid", 32'(owner_valid), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_credits", 32'(credits_used), 32'd0);
    chk("reset_start", 32'(uart_start), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Three-byte message from requester 0.
    w0 = wr_times.size();
    put(0, 8'h41, 1'b0);
    put(0, 8'h42, 1'b0);
    put(0, 8'h43, 1'b1);
    expect_b(0, 8'h41);
    expect_b(0, 8'h42);
    expect_b(0, 8'h43);
    en = 4'b0001;
    drain("t1_drain", 40);
    chk("t1_idle", 32'(owner_valid), 32'd0);
    chk("t1_credits3", 32'(credits_used), 32'd3);
    chk("t1_b2b_a", 32'(wr_times[w0+1] - wr_times[w0]), 32'd1);
    chk("t1_b2b_b", 32'(wr_times[w0+2] - wr_times[w0+1]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      busy_man = 1'b1;
      @(posedge clk); #1;
      busy_man = 1'b0;
      @(posedge clk); #1;
    end
    chk("t1_credits0", 32'(credits_used), 32'd0);
    chk("t1_start0", 32'(uart_start), 32'd0);

    // Round-robin order 0,1,3,0 with one-byte messages.
    do_reset();
    w0 = wr_times.size();
    put(0, 8'h10, 1'b1);
    put(0, 8'h11, 1'b1);
    put(1, 8'h20, 1'b1);
    put(3, 8'h30, 1'b1);
    expect_b(0, 8'h10);
    expect_b(1, 8'h20);
    expect_b(3, 8'h30);
    expect_b(0, 8'h11);
    en = 4'b1011;
    drain("t2_drain", 40);
    for (int k = 0; k < 3; k++)
      chk("t2_gap", 32'(wr_times[w0+k+1] - wr_times[w0+k]), 32'd2);

    // 20-byte stream on requester 2 split 8/8/4, req0 interleaved.
    do_reset();
    g0 = grants;
    put(0, 8'hA0, 1'b1);
    put(0, 8'hA1, 1'b1);
    for (int k = 0; k < 20; k++) put(2, 8'(k), 1'b0);
    expect_b(0, 8'hA0);
    for (int k = 0; k < 8; k++) expect_b(2, 8'(k));
    expect_b(0, 8'hA1);
    for (int k = 8; k < 20; k++) expect_b(2, 8'(k));
    en = 4'b0101;
    auto_busy = 1'b1;
    drain("t3_drain", 400);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_grants", 32'(grants - g0), 32'd5);
    chk("t3_hold_valid", 32'(owner_valid), 32'd1);
    chk("t3_hold_owner", 32'(owner), 32'd2);

    // Credit limit with uart_busy held high.
    do_reset();
    busy_man = 1'b1;
    for (int k = 0; k < 17; k++) begin
      put(0, 8'(8'h50 + k), k == 16);
      expect_b(0, 8'(8'h50 + k));
    end
    en = 4'b0001;
    for (int k = 0; k < 80 && credits_used != 5'd16; k++) begin
      @(posedge clk); #1;
    end
    chk("t4_full", 32'(credits_used), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_locked", 32'(owner_valid), 32'd1);
    chk("t4_ready_low", 32'(req_ready), 32'd0);
    chk("t4_pending", 32'(sb.size()), 32'd1);
    busy_man = 1'b0;
    @(posedge clk); #1;
    busy_man = 1'b1;
    chk("t4_credits15", 32'(credits_used), 32'd15);
    chk("t4_ready_up", 32'(req_ready), 32'd1);
    drain("t4_drain", 10);
    chk("t4_refull", 32'(credits_used), 32'd16);

    // Transfer and busy fall in the same cycle at credits 5.
    do_reset();
    busy_man = 1'b1;
    for (int k = 0; k < 5; k++) begin
      put(0, 8'(8'h60 + k), 1'b0);
      expect_b(0, 8'(8'h60 + k));
    end
    en = 4'b0001;
    drain("t5_drain", 20);
    @(posedge clk); #1;
    chk("t5_pre", 32'(credits_used), 32'd5);
    put(0, 8'h65, 1'b1);
    expect_b(0, 8'h65);
    busy_man = 1'b0;
    @(posedge clk); #1;
    busy_man = 1'b1;
    chk("t5_sent", 32'(sb.size()), 32'd0);
    chk("t5_same", 32'(credits_used), 32'd5);

    // Reset mid-burst at credits 4.
    do_reset();
    busy_man = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(1, 8'(8'h70 + k), 1'b0);
      expect_b(1, 8'(8'h70 + k));
    end
    en = 4'b0010;
    drain("t6_drain", 20);
    chk("t6_pre_credits", 32'(credits_used), 32'd4);
    chk("t6_pre_owner", 32'(owner), 32'd1);
    do_reset();
    chk("t6_idle", 32'(owner_valid), 32'd0);
    chk("t6_credits", 32'(credits_used), 32'd0);
    chk("t6_start", 32'(uart_start), 32'd0);
    chk("t6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    put(3, 8'h83, 1'b1);
    put(0, 8'h80, 1'b1);
    expect_b(0, 8'h80);
    expect_b(3, 8'h83);
    en = 4'b1001;
    drain("t6_after", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
